// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and default widths for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MSUB  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MTLO  = 4'd7;

    localparam int DIV_BITS_DEFAULT = 32;
    localparam int MUL_LAT_DEFAULT  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_DIV   = 3'd2,
        ST_FIX   = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    // MADD/MSUB are the signed accumulate forms.
    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_step.sv
// One combinational restoring-divide step: shift the next dividend bit into the remainder and trial-subtract.
module div_step_unit #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] quot,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] quot_next
);

    logic [W:0] shifted;
    logic [W:0] diff;
    logic       fits;

    // quot holds the not-yet-consumed dividend bits at the top and the quotient bits at the bottom.
    assign shifted   = {rem, quot[W-1]};
    assign diff      = shifted - {1'b0, divisor};
    assign fits      = (shifted >= {1'b0, divisor});
    assign rem_next  = fits ? diff[W-1:0] : shifted[W-1:0];
    assign quot_next = {quot[W-2:0], fits};

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer: accepts one multiply/divide/accumulate/move op, stalls while it runs, and
// issues a single-cycle write of the {HI,LO} result.
module hilo_muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT  = MUL_LAT_DEFAULT,
    parameter int DIV_BITS = DIV_BITS_DEFAULT
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [3:0]            Op,
    input  logic [DIV_BITS-1:0]   OperandA,
    input  logic [DIV_BITS-1:0]   OperandB,
    input  logic                  Flush,
    input  logic [2*DIV_BITS-1:0] HiLoReg,
    output logic                  Busy,
    output logic                  HiLoWriteEnable,
    output logic [2*DIV_BITS-1:0] HiLoWriteData,
    output logic                  DivByZero
);

    localparam int W       = DIV_BITS;
    localparam int CNT_MAX = (MUL_LAT > DIV_BITS) ? MUL_LAT : DIV_BITS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       op_reg, op_next;
    logic [2*W-1:0]   prod_reg, prod_next;
    logic [W-1:0]     rem_reg, rem_next;
    logic [W-1:0]     quot_reg, quot_next;
    logic [W-1:0]     divisor_reg, divisor_next;
    logic             neg_q_reg, neg_q_next;
    logic             neg_r_reg, neg_r_next;
    logic [2*W-1:0]   data_reg, data_next;
    logic             dbz_reg, dbz_next;

    logic             accept;
    logic             sgn;
    logic [W-1:0]     abs_a, abs_b;
    logic [2*W-1:0]   a_ext, b_ext, prod_live;
    logic [W-1:0]     step_rem, step_quot;

    assign accept = (state_reg == ST_IDLE) && Start && !Flush;
    assign sgn    = is_signed_op(Op);
    assign abs_a  = (sgn && OperandA[W-1]) ? -OperandA : OperandA;
    assign abs_b  = (sgn && OperandB[W-1]) ? -OperandB : OperandB;

    // Extending to full width first makes one unsigned multiply give the right signed product mod 2^(2W).
    assign a_ext     = sgn ? {{W{OperandA[W-1]}}, OperandA} : {{W{1'b0}}, OperandA};
    assign b_ext     = sgn ? {{W{OperandB[W-1]}}, OperandB} : {{W{1'b0}}, OperandB};
    assign prod_live = a_ext * b_ext;

    div_step_unit #(.W(W)) u_div_step (
        .rem       (rem_reg),
        .quot      (quot_reg),
        .divisor   (divisor_reg),
        .rem_next  (step_rem),
        .quot_next (step_quot)
    );

    function automatic logic [2*W-1:0] mul_result(input logic [3:0] op, input logic [2*W-1:0] prod,
                                                  input logic [2*W-1:0] hilo);
        case (op)
            OP_MADD: return hilo + prod;
            OP_MSUB: return hilo - prod;
            default: return prod;
        endcase
    endfunction

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        op_next      = op_reg;
        prod_next    = prod_reg;
        rem_next     = rem_reg;
        quot_next    = quot_reg;
        divisor_next = divisor_reg;
        neg_q_next   = neg_q_reg;
        neg_r_next   = neg_r_reg;
        data_next    = data_reg;
        dbz_next     = dbz_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    dbz_next = 1'b0;
                    op_next  = Op;
                    case (Op)
                        OP_MTHI: begin
                            data_next  = {OperandA, HiLoReg[W-1:0]};
                            state_next = ST_WRITE;
                        end
                        OP_MTLO: begin
                            data_next  = {HiLoReg[2*W-1:W], OperandA};
                            state_next = ST_WRITE;
                        end
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                            prod_next = prod_live;
                            if (MUL_LAT <= 1) begin
                                data_next  = mul_result(Op, prod_live, HiLoReg);
                                state_next = ST_WRITE;
                            end else begin
                                cnt_next   = CNT_W'(MUL_LAT - 1);
                                state_next = ST_MUL;
                            end
                        end
                        OP_DIV, OP_DIVU: begin
                            if (OperandB == '0) begin
                                data_next  = {OperandA, {W{1'b1}}};
                                dbz_next   = 1'b1;
                                state_next = ST_WRITE;
                            end else begin
                                rem_next     = '0;
                                quot_next    = abs_a;
                                divisor_next = abs_b;
                                neg_q_next   = sgn && (OperandA[W-1] ^ OperandB[W-1]);
                                neg_r_next   = sgn && OperandA[W-1];
                                cnt_next     = CNT_W'(DIV_BITS - 1);
                                state_next   = ST_DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_next == '0) begin
                    data_next  = mul_result(op_reg, prod_reg, HiLoReg);
                    state_next = ST_WRITE;
                end
            end
            ST_DIV: begin
                rem_next  = step_rem;
                quot_next = step_quot;
                if (cnt_reg == '0) begin
                    state_next = ST_FIX;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_FIX: begin
                data_next  = {(neg_r_reg ? -rem_reg : rem_reg), (neg_q_reg ? -quot_reg : quot_reg)};
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (Flush && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            op_reg      <= '0;
            prod_reg    <= '0;
            rem_reg     <= '0;
            quot_reg    <= '0;
            divisor_reg <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            data_reg    <= '0;
            dbz_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            op_reg      <= op_next;
            prod_reg    <= prod_next;
            rem_reg     <= rem_next;
            quot_reg    <= quot_next;
            divisor_reg <= divisor_next;
            neg_q_reg   <= neg_q_next;
            neg_r_reg   <= neg_r_next;
            data_reg    <= data_next;
            dbz_reg     <= dbz_next;
        end
    end

    // Flush comes from rising-edge pipeline flops, so gating the strobe with it is settled before
    // the HI/LO register captures on the falling edge.
    assign Busy            = (state_reg != ST_IDLE);
    assign HiLoWriteEnable = (state_reg == ST_WRITE) && !Flush;
    assign HiLoWriteData   = data_reg;
    assign DivByZero       = dbz_reg;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed vector table, random ops against an
// arithmetic reference model, and hand-written flush/reset/busy sequences.
module tb_hilo_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int MUL_LAT  = 4;
    localparam int DIV_BITS = 32;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [3:0]  Op;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic        Flush;
    logic [63:0] HiLoReg;
    logic        Busy;
    logic        HiLoWriteEnable;
    logic [63:0] HiLoWriteData;
    logic        DivByZero;

    int errors = 0;
    int checks = 0;

    hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_BITS(DIV_BITS)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Start           (Start),
        .Op              (Op),
        .OperandA        (OperandA),
        .OperandB        (OperandB),
        .Flush           (Flush),
        .HiLoReg         (HiLoReg),
        .Busy            (Busy),
        .HiLoWriteEnable (HiLoWriteEnable),
        .HiLoWriteData   (HiLoWriteData),
        .DivByZero       (DivByZero)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hilo;
        logic [63:0] exp_data;
        int          exp_lat;
        logic        exp_dbz;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] hilo, input logic [63:0] exp_data, input int exp_lat,
                           input logic exp_dbz);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.hilo = hilo;
        v.exp_data = exp_data; v.exp_lat = exp_lat; v.exp_dbz = exp_dbz;
        vecs.push_back(v);
    endtask

    // Reference: plain integer arithmetic on 64-bit values; SV division truncates toward zero
    // and the remainder follows the dividend's sign.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [63:0] hilo, output logic [63:0] d, output int lat,
                                  output logic dbz);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        d = 64'd0; lat = MUL_LAT; dbz = 1'b0;
        case (op)
            OP_MULT:  d = sa * sb;
            OP_MULTU: d = ua * ub;
            OP_MADD:  d = hilo + 64'(sa * sb);
            OP_MSUB:  d = hilo - 64'(sa * sb);
            OP_MTHI:  begin d = {a, hilo[31:0]}; lat = 1; end
            OP_MTLO:  begin d = {hilo[63:32], a}; lat = 1; end
            OP_DIV, OP_DIVU: begin
                if (b == 32'd0) begin
                    d = {a, 32'hFFFFFFFF}; lat = 1; dbz = 1'b1;
                end else if (op == OP_DIV) begin
                    q = sa / sb; r = sa % sb;
                    d = {r[31:0], q[31:0]}; lat = DIV_BITS + 2;
                end else begin
                    uq = ua / ub; ur = ua % ub;
                    d = {ur[31:0], uq[31:0]}; lat = DIV_BITS + 2;
                end
            end
            default: lat = 0;
        endcase
    endfunction

    // Issues one op (entered away from the rising edge) and watches until the write strobe is gone.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] hilo, output int lat, output logic [63:0] data,
                          output logic dbz, output int pulses);
        Op = op; OperandA = a; OperandB = b; HiLoReg = hilo; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        lat = 0; data = 64'd0; dbz = 1'b0; pulses = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge Clk);
            if (HiLoWriteEnable) begin
                if (pulses == 0) begin
                    lat = c; data = HiLoWriteData; dbz = DivByZero;
                end
                pulses++;
            end else if (pulses > 0) begin
                break;
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic apply(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] hilo, input logic [63:0] exp_data, input int exp_lat,
                         input logic exp_dbz);
        int          lat, pulses;
        logic [63:0] data;
        logic        dbz;
        run_op(op, a, b, hilo, lat, data, dbz, pulses);
        $display("txn %s op=%0d a=%h b=%h hilo=%h -> data=%h lat=%0d dbz=%b pulses=%0d",
                 name, op, a, b, hilo, data, lat, dbz, pulses);
        check({name, " pulses"}, 64'(pulses), 64'd1);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " data"}, data, exp_data);
        check({name, " divbyzero"}, {63'd0, dbz}, {63'd0, exp_dbz});
        check({name, " busy after write"}, {63'd0, Busy}, 64'd0);
    endtask

    initial begin
        int          pulses;
        logic [63:0] d;
        int          lat;
        logic        dbz;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] rh;

        Reset = 1'b0; Start = 1'b0; Op = 4'd0; OperandA = '0; OperandB = '0; Flush = 1'b0; HiLoReg = '0;

        add_vec("mult_neg",    OP_MULT,  32'hFFFFFFFD, 32'd5,        64'd0,                 64'hFFFFFFFF_FFFFFFF1, 4,  1'b0);
        add_vec("multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'd2,        64'd0,                 64'h00000001_FFFFFFFE, 4,  1'b0);
        add_vec("div_neg",     OP_DIV,   32'hFFFFFFF9, 32'd2,        64'd0,                 64'hFFFFFFFF_FFFFFFFD, 34, 1'b0);
        add_vec("div_ovf",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'd0,                 64'h00000000_80000000, 34, 1'b0);
        add_vec("divu_zero",   OP_DIVU,  32'd9,        32'd0,        64'd0,                 64'h00000009_FFFFFFFF, 1,  1'b1);
        add_vec("madd",        OP_MADD,  32'd2,        32'd3,        64'h00000001_00000000, 64'h00000001_00000006, 4,  1'b0);
        add_vec("mtlo",        OP_MTLO,  32'h000000AB, 32'd0,        64'h12345678_9ABCDEF0, 64'h12345678_000000AB, 1,  1'b0);
        add_vec("mthi",        OP_MTHI,  32'hCAFEF00D, 32'd0,        64'h12345678_9ABCDEF0, 64'hCAFEF00D_9ABCDEF0, 1,  1'b0);
        add_vec("msub_wrap",   OP_MSUB,  32'd1,        32'd1,        64'd0,                 64'hFFFFFFFF_FFFFFFFF, 4,  1'b0);
        add_vec("divu_basic",  OP_DIVU,  32'd100,      32'd7,        64'd0,                 64'h00000002_0000000E, 34, 1'b0);
        add_vec("div_zero_s",  OP_DIV,   32'hFFFFFFF0, 32'd0,        64'd0,                 64'hFFFFFFF0_FFFFFFFF, 1,  1'b1);

        // Reset state
        repeat (2) @(negedge Clk);
        check("reset busy", {63'd0, Busy}, 64'd0);
        check("reset we", {63'd0, HiLoWriteEnable}, 64'd0);
        check("reset data", HiLoWriteData, 64'd0);
        check("reset divbyzero", {63'd0, DivByZero}, 64'd0);
        Reset = 1'b1;
        @(negedge Clk);

        foreach (vecs[i]) begin
            apply(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hilo,
                  vecs[i].exp_data, vecs[i].exp_lat, vecs[i].exp_dbz);
        end

        // Sticky divide-by-zero, then cleared by the next accepted op
        apply("divu_zero2", OP_DIVU, 32'd5, 32'd0, 64'd0, 64'h00000005_FFFFFFFF, 1, 1'b1);
        repeat (2) @(negedge Clk);
        check("divbyzero sticky", {63'd0, DivByZero}, 64'd1);
        Op = OP_MTLO; OperandA = 32'd1; Start = 1'b1;
        @(posedge Clk); #1; Start = 1'b0;
        @(negedge Clk);
        check("divbyzero cleared", {63'd0, DivByZero}, 64'd0);
        @(negedge Clk);

        // Reset in the middle of a divide
        Op = OP_DIVU; OperandA = 32'd100; OperandB = 32'd7; Start = 1'b1;
        @(posedge Clk); #1; Start = 1'b0;
        repeat (9) @(posedge Clk);
        #2; Reset = 1'b0; #1;
        $display("txn reset_mid_div busy=%b we=%b", Busy, HiLoWriteEnable);
        check("reset mid div busy", {63'd0, Busy}, 64'd0);
        check("reset mid div we", {63'd0, HiLoWriteEnable}, 64'd0);
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk);
        apply("divu_after_reset", OP_DIVU, 32'd100, 32'd7, 64'd0, 64'h00000002_0000000E, 34, 1'b0);

        // Start held while busy must not queue a second op
        Op = OP_MULT; OperandA = 32'd6; OperandB = 32'd7; HiLoReg = 64'd0; Start = 1'b1;
        @(posedge Clk); #1;
        Op = OP_MTHI; OperandA = 32'hDEAD0000;
        pulses = 0; d = 64'd0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge Clk);
            if (HiLoWriteEnable) begin pulses++; d = HiLoWriteData; end
            @(posedge Clk); #1;
            if (c == 2) Start = 1'b0;
        end
        $display("txn start_while_busy pulses=%0d data=%h", pulses, d);
        check("busy start pulses", 64'(pulses), 64'd1);
        check("busy start data", d, 64'd42);

        // Flush during a multiply and during a divide
        for (int k = 0; k < 2; k++) begin
            Op = (k == 0) ? OP_MULT : OP_DIV; OperandA = 32'd50; OperandB = 32'd3; Start = 1'b1;
            @(posedge Clk); #1; Start = 1'b0;
            repeat ((k == 0) ? 1 : 4) @(posedge Clk);
            #1; Flush = 1'b1;
            @(posedge Clk); #1; Flush = 1'b0;
            pulses = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge Clk);
                if (HiLoWriteEnable) pulses++;
            end
            $display("txn flush_mid_op k=%0d pulses=%0d busy=%b", k, pulses, Busy);
            check("flush mid op pulses", 64'(pulses), 64'd0);
            check("flush mid op busy", {63'd0, Busy}, 64'd0);
        end

        // Flush during the write cycle
        Op = OP_MULT; OperandA = 32'd9; OperandB = 32'd9; Start = 1'b1;
        @(posedge Clk); #1; Start = 1'b0;
        repeat (3) @(posedge Clk);
        #1; Flush = 1'b1;
        @(negedge Clk);
        check("flush in write we", {63'd0, HiLoWriteEnable}, 64'd0);
        @(posedge Clk); #1; Flush = 1'b0;
        @(negedge Clk);
        $display("txn flush_in_write busy=%b we=%b", Busy, HiLoWriteEnable);
        check("flush in write busy", {63'd0, Busy}, 64'd0);
        check("flush in write we after", {63'd0, HiLoWriteEnable}, 64'd0);

        // Flush and Start together: op is not accepted
        Op = OP_MTHI; OperandA = 32'h11111111; Start = 1'b1; Flush = 1'b1;
        @(posedge Clk); #1; Start = 1'b0; Flush = 1'b0;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            if (HiLoWriteEnable || Busy) pulses++;
        end
        $display("txn flush_with_start activity=%0d", pulses);
        check("flush with start activity", 64'(pulses), 64'd0);

        // Unknown op code is a no-op
        Op = 4'd11; OperandA = 32'd1; OperandB = 32'd1; Start = 1'b1;
        @(posedge Clk); #1; Start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            if (HiLoWriteEnable || Busy) pulses++;
        end
        $display("txn unknown_op activity=%0d", pulses);
        check("unknown op activity", 64'(pulses), 64'd0);

        // Random ops against the reference model
        for (int n = 0; n < 120; n++) begin
            rop = 4'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            rh  = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 20));
                3: ra = -ra;
                default: ;
            endcase
            model(rop, ra, rb, rh, d, lat, dbz);
            apply("random", rop, ra, rb, rh, d, lat, dbz);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
